// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus_master peripheral-bus sequencer.
//   - State encodings (IDLE, SETUP, STROBE, HOLD, TURN) and the matching state_e enum.
//   - Default timing constants for the top-level parameters.
//   - cnt_width(): phase-counter width, the clog2 of the longest phase (at least 1 bit).
package bus_master_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] TURN   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StSetup  = SETUP,
    StStrobe = STROBE,
    StHold   = HOLD,
    StTurn   = TURN
  } state_e;

  localparam int DefSetupCyc  = 2;
  localparam int DefStrobeCyc = 3;
  localparam int DefHoldCyc   = 1;
  localparam int DefTurnCyc   = 2;

  // A phase of N cycles loads N-1, so clog2(N) bits suffice; never less than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable phase down-counter for bus_master.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset (counter cleared)
//   load_i      load strobe; load_val_i is taken on this edge
//   load_val_i  value to load (phase length minus one)
//   done_o      high while the count is zero
// Without a load the count decrements and saturates at zero.
module bus_phase_timer #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bus_master.sv
// Sequencer for the external parallel peripheral bus.
// Accepts single read/write requests on a valid/ready handshake and generates address,
// chip-select and strobe timing: IDLE -> SETUP -> STROBE -> HOLD -> (TURN on reads) -> IDLE.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready high only in IDLE)
//   req_we/addr/wdata   request fields, latched on accept
//   rsp_valid           one-cycle completion pulse on return to IDLE
//   rsp_rdata           last captured read data
//   busy                high whenever not IDLE
//   bus_out/bus_oe      per-bit pad drive value and output enable
//   bus_in              per-bit pad input value
//   addr_o, cs_n        address pins, active-low chip select
//   wr_n, rd_n          active-low write / read strobes
// Optional: define BUS_MASTER_INPUT_SYNC_EN to pass bus_in through a two-flop synchronizer;
// STROBE is then extended by 2 cycles and capture happens on its final cycle.
// All outputs are registered; output registers are updated from the next state.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int SETUP_CYC  = DefSetupCyc,
  parameter int STROBE_CYC = DefStrobeCyc,
  parameter int HOLD_CYC   = DefHoldCyc,
  parameter int TURN_CYC   = DefTurnCyc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic [ADDR_W-1:0] addr_o,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n
);

  logic [DATA_W-1:0] cap_data;

`ifdef BUS_MASTER_INPUT_SYNC_EN
  localparam int StrobeLen = STROBE_CYC + 2;

  logic [DATA_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus_in;
      sync2_q <= sync1_q;
    end
  end

  assign cap_data = sync2_q;
`else
  localparam int StrobeLen = STROBE_CYC;

  assign cap_data = bus_in;
`endif

  localparam int CntW     = cnt_width(SETUP_CYC, StrobeLen, HOLD_CYC, TURN_CYC);
  localparam int TurnLoad = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;

  state_e            state_q;
  logic              we_q;
  logic              req_ready_q, rsp_valid_q, busy_q;
  logic [DATA_W-1:0] rsp_rdata_q, bus_oe_q, bus_out_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cs_n_q, wr_n_q, rd_n_q;

  logic              tmr_load;
  logic [CntW-1:0]   tmr_val;
  logic              tmr_done;

  // Load the next phase length on the same edge that enters that phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          tmr_load = 1'b1;
          tmr_val  = CntW'(SETUP_CYC - 1);
        end
      end
      StSetup: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CntW'(StrobeLen - 1);
        end
      end
      StStrobe: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CntW'(HOLD_CYC - 1);
        end
      end
      StHold: begin
        if (tmr_done && !we_q && (TURN_CYC > 0)) begin
          tmr_load = 1'b1;
          tmr_val  = CntW'(TurnLoad);
        end
      end
      default: ;
    endcase
  end

  bus_phase_timer #(
    .CntW(CntW)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      bus_oe_q    <= '0;
      bus_out_q   <= '0;
      addr_q      <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q     <= StSetup;
            we_q        <= req_we;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= req_addr;
            cs_n_q      <= 1'b0;
            bus_oe_q    <= {DATA_W{req_we}};
            bus_out_q   <= req_we ? req_wdata : '0;
          end
        end
        StSetup: begin
          if (tmr_done) begin
            state_q <= StStrobe;
            wr_n_q  <= ~we_q;
            rd_n_q  <= we_q;
          end
        end
        StStrobe: begin
          if (tmr_done) begin
            state_q <= StHold;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            if (!we_q) rsp_rdata_q <= cap_data;
          end
        end
        StHold: begin
          if (tmr_done) begin
            cs_n_q    <= 1'b1;
            bus_oe_q  <= '0;
            bus_out_q <= '0;
            // TURN keeps the bus idle after a read before anyone may drive it again.
            if (!we_q && (TURN_CYC > 0)) begin
              state_q <= StTurn;
            end else begin
              state_q     <= StIdle;
              rsp_valid_q <= 1'b1;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        StTurn: begin
          if (tmr_done) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign bus_oe    = bus_oe_q;
  assign bus_out   = bus_out_q;
  assign addr_o    = addr_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign rd_n      = rd_n_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master: one instance with default timing and one
// with SETUP=1, STROBE=1, HOLD=1, TURN=0 for continuous back-to-back reads.
module tb_bus_master;

`ifdef BUS_MASTER_INPUT_SYNC_EN
  localparam int SE = 2;
`else
  localparam int SE = 0;
`endif
  localparam int WrLat = 7;
  localparam int RdLat = 9 + SE;
  localparam int FastPeriod = 4 + SE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_ready, req_we, rsp_valid, busy, cs_n, wr_n, rd_n;
  logic [3:0] req_addr, addr_o;
  logic [7:0] req_wdata, rsp_rdata, bus_out, bus_oe, bus_in, rd_val;

  logic       f_req_valid, f_req_ready, f_req_we, f_rsp_valid, f_busy, f_cs_n, f_wr_n, f_rd_n;
  logic [3:0] f_req_addr, f_addr_o;
  logic [7:0] f_req_wdata, f_rsp_rdata, f_bus_out, f_bus_oe, f_bus_in;

  // Peripheral models: drive read data only while the read strobe is low.
  assign bus_in   = rd_n ? 8'hE7 : rd_val;
  assign f_bus_in = f_rd_n ? 8'h00 : {f_addr_o, ~f_addr_o};

  bus_master u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .bus_in   (bus_in),
    .addr_o   (addr_o),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n)
  );

  bus_master #(
    .SETUP_CYC (1),
    .STROBE_CYC(1),
    .HOLD_CYC  (1),
    .TURN_CYC  (0)
  ) u_fast (
    .clk      (clk),
    .rst      (rst),
    .req_valid(f_req_valid),
    .req_ready(f_req_ready),
    .req_we   (f_req_we),
    .req_addr (f_req_addr),
    .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid),
    .rsp_rdata(f_rsp_rdata),
    .busy     (f_busy),
    .bus_out  (f_bus_out),
    .bus_oe   (f_bus_oe),
    .bus_in   (f_bus_in),
    .addr_o   (f_addr_o),
    .cs_n     (f_cs_n),
    .wr_n     (f_wr_n),
    .rd_n     (f_rd_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       cs_h [40];
  logic       wr_h [40];
  logic       rd_h [40];
  logic       rv_h [40];
  logic       rdy_h[40];
  logic [7:0] oe_h [40];
  logic [7:0] out_h[40];
  logic [3:0] a_h  [40];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request, then sample ncyc cycles (index k = cycles after accept).
  // b2b_at: cycle at which a write (addr 9, data 6D) is presented; rst_at: reset pulse cycle.
  task automatic run(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                     input int ncyc, input int b2b_at, input int rst_at);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    check("ready_pre", {31'd0, req_ready}, 32'd1);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cs_h[k]  = cs_n;
      wr_h[k]  = wr_n;
      rd_h[k]  = rd_n;
      rv_h[k]  = rsp_valid;
      rdy_h[k] = req_ready;
      oe_h[k]  = bus_oe;
      out_h[k] = bus_out;
      a_h[k]   = addr_o;
      if (k == 1) begin
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wd;
      end
      if (k == b2b_at) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'h9;
        req_wdata = 8'h6D;
      end
      if (k == b2b_at + 1) req_valid = 1'b0;
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) rst = 1'b0;
    end
  endtask

  // sel: 0 cs_n low, 1 wr_n low, 2 rd_n low, 3 rsp_valid high, 4 bus_oe nonzero.
  function automatic int stat(input int sel, input int n, input bit first);
    int  c = 0;
    int  f = 0;
    bit  act;
    for (int k = 1; k <= n; k++) begin
      case (sel)
        0:       act = !cs_h[k];
        1:       act = !wr_h[k];
        2:       act = !rd_h[k];
        3:       act = rv_h[k];
        default: act = (oe_h[k] != 8'h00);
      endcase
      if (act) begin
        c++;
        if (f == 0) f = k;
      end
    end
    return first ? f : c;
  endfunction

  initial begin
    logic [3:0] exp_q[$];
    int         bad, last, nrsp;
    bit         inc;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rd_val = '0;
    f_req_valid = 1'b0; f_req_we = 1'b0; f_req_addr = '0; f_req_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_oe_out", {16'd0, bus_oe, bus_out}, 32'd0);
    check("rst_addr", {28'd0, addr_o}, 32'd0);
    check("rst_strobes", {29'd0, cs_n, wr_n, rd_n}, 32'd7);
    check("rst_f_ready", {31'd0, f_req_ready}, 32'd1);
    rst = 1'b0;

    // Write 0xA3 to 0x5.
    run(1'b1, 4'h5, 8'hA3, 9, 0, 0);
    check("wr_cs_cnt", stat(0, 9, 0), 6);
    check("wr_cs_first", stat(0, 9, 1), 1);
    check("wr_wr_cnt", stat(1, 9, 0), 3);
    check("wr_wr_first", stat(1, 9, 1), 3);
    check("wr_rd_cnt", stat(2, 9, 0), 0);
    check("wr_oe_cnt", stat(4, 9, 0), 6);
    check("wr_rv_cnt", stat(3, 9, 0), 1);
    check("wr_rv_first", stat(3, 9, 1), WrLat);
    bad = 0;
    for (int k = 1; k <= 9; k++)
      if (!cs_h[k] && (oe_h[k] != 8'hFF || out_h[k] != 8'hA3)) bad++;
    check("wr_data_drive", bad, 0);
    check("wr_addr", {28'd0, a_h[1]}, 32'h5);
    check("wr_ready_mid", {31'd0, rdy_h[3]}, 32'd0);
    check("wr_ready_end", {31'd0, rdy_h[WrLat]}, 32'd1);
    check("wr_busy_end", {31'd0, busy}, 32'd0);

    // Read 0x2, peripheral returns 0x3C during strobe.
    rd_val = 8'h3C;
    run(1'b0, 4'h2, 8'h00, RdLat + 1, 0, 0);
    check("rd_rd_cnt", stat(2, RdLat + 1, 0), 3 + SE);
    check("rd_rd_first", stat(2, RdLat + 1, 1), 3);
    check("rd_wr_cnt", stat(1, RdLat + 1, 0), 0);
    check("rd_oe_cnt", stat(4, RdLat + 1, 0), 0);
    check("rd_cs_cnt", stat(0, RdLat + 1, 0), 6 + SE);
    check("rd_rv_first", stat(3, RdLat + 1, 1), RdLat);
    check("rd_rv_cnt", stat(3, RdLat + 1, 0), 1);
    check("rd_addr", {28'd0, a_h[1]}, 32'h2);
    check("rd_rdata", {24'd0, rsp_rdata}, 32'h3C);

    // Read 0x1 then a write accepted on the read's rsp_valid cycle.
    rd_val = 8'h5A;
    run(1'b0, 4'h1, 8'h00, RdLat + 8, RdLat, 0);
    check("b2b_rv", {31'd0, rv_h[RdLat]}, 32'd1);
    check("b2b_ready", {31'd0, rdy_h[RdLat]}, 32'd1);
    check("b2b_turn_cs", {30'd0, cs_h[7 + SE], cs_h[8 + SE]}, 32'd3);
    check("b2b_turn_oe", {16'd0, oe_h[7 + SE], oe_h[8 + SE]}, 32'd0);
    check("b2b_oe_first", stat(4, RdLat + 8, 1), RdLat + 1);
    check("b2b_setup_cs", {31'd0, cs_h[RdLat + 1]}, 32'd0);
    check("b2b_setup_drv", {16'd0, oe_h[RdLat + 1], out_h[RdLat + 1]}, 32'hFF6D);
    check("b2b_wr_rv", {31'd0, rv_h[RdLat + 7]}, 32'd1);
    check("b2b_rdata_kept", {24'd0, rsp_rdata}, 32'h5A);

    // Reset during write STROBE.
    run(1'b1, 4'h7, 8'h81, 8, 0, 4);
    check("rst_mid_wr_low", {31'd0, wr_h[4]}, 32'd0);
    check("rst_mid_after", {28'd0, wr_h[5], cs_h[5], rdy_h[5], rv_h[5]}, 32'hE);
    check("rst_mid_oe", {24'd0, oe_h[5]}, 32'd0);
    check("rst_mid_rv_cnt", stat(3, 8, 0), 0);
    check("rst_mid_rdata", {24'd0, rsp_rdata}, 32'd0);

    // Continuous reads on the fast instance.
    f_req_valid = 1'b1;
    f_req_addr  = 4'h3;
    last = -1; nrsp = 0; inc = 1'b0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (f_req_ready) begin
        exp_q.push_back(f_req_addr);
        inc = 1'b1;
      end
      @(negedge clk);
      if (inc) begin
        f_req_addr = f_req_addr + 4'd1;
        inc = 1'b0;
      end
      if (!f_wr_n || f_bus_oe != 8'h00 || f_bus_out != 8'h00) bad++;
      if (f_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("f_queue", 32'd0, 32'd1);
        end else begin
          check("f_rdata", {24'd0, f_rsp_rdata}, {24'd0, exp_q[0], ~exp_q[0]});
          void'(exp_q.pop_front());
        end
        if (last >= 0) check("f_period", k - last, FastPeriod);
        last = k;
        nrsp++;
      end
    end
    f_req_valid = 1'b0;
    check("f_count", nrsp, 40 / FastPeriod);
    check("f_no_drive", bad, 0);
    repeat (10) @(negedge clk);
    check("f_idle", {30'd0, f_busy, f_cs_n}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
